// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mdu_sequencer
// Description : Control sequencer for the shared iterative multiply/divide
//               unit in the EX stage. Starts the MDU on an M-extension op,
//               counts its fixed latency while stalling the front end, then
//               steers the MDU result into EX/MEM for one cycle. A flush
//               aborts an in-flight op.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = $clog2(DIV_LAT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_valid,
    input  logic       ex_is_mdu,
    input  logic [2:0] ex_funct3,
    input  logic       ex_rs2_zero,
    input  logic       flush,
    output logic       mdu_start,
    output logic [2:0] mdu_op,
    output logic       mdu_abort,
    output logic       PCwrite,
    output logic       IF_IDwrite,
    output logic       ID_EXwrite,
    output logic       EX_MEMbubble,
    output logic       result_sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter preload values are latency minus one: the start cycle itself
    // is the first cycle of the latency window.
    localparam logic [CNT_W-1:0] c_mul_m1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_div_m1 = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;

    logic             w_trigger;
    logic [CNT_W-1:0] w_lat_m1;
    logic             w_we;

    // A new op may only be accepted while idle and not being killed.
    assign w_trigger = (r_state == S_IDLE) && ex_valid && ex_is_mdu && !flush;

    // Effective latency minus one; divide by zero completes in a single cycle.
    always_comb begin
        if (ex_funct3[2] && ex_rs2_zero) begin
            w_lat_m1 = '0;
        end else if (ex_funct3[2]) begin
            w_lat_m1 = c_div_m1;
        end else begin
            w_lat_m1 = c_mul_m1;
        end
    end

    // State, latency counter and captured opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_op    <= ex_funct3;
                        r_cnt   <= w_lat_m1;
                        r_state <= (w_lat_m1 == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    // Flush wins over counter expiry.
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt <= c_one) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt - c_one;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Pipeline control decoded from the registered state plus this cycle's
    // trigger/flush, so the stall takes effect in the same cycle as start.
    always_comb begin
        mdu_start    = 1'b0;
        mdu_abort    = 1'b0;
        w_we         = 1'b1;
        EX_MEMbubble = 1'b0;
        result_sel   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    mdu_start    = 1'b1;
                    w_we         = 1'b0;
                    EX_MEMbubble = 1'b1;
                end
            end
            S_RUN: begin
                EX_MEMbubble = 1'b1;
                if (flush) begin
                    mdu_abort = 1'b1;
                end else begin
                    w_we      = 1'b0;
                end
            end
            S_DONE: begin
                if (flush) begin
                    mdu_abort    = 1'b1;
                    EX_MEMbubble = 1'b1;
                end else begin
                    result_sel   = 1'b1;
                end
            end
            default: begin
                w_we = 1'b1;
            end
        endcase
    end

    assign PCwrite    = w_we;
    assign IF_IDwrite = w_we;
    assign ID_EXwrite = w_we;
    assign mdu_op     = r_op;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
